// File: rtl/lsu_riscv.sv
// RISC-V load/store unit: aligns core accesses onto a 32-bit word memory port
// and formats load data. One outstanding access, IDLE -> BUSY -> DONE.
module lsu_riscv (
    input  logic        clk_i,
    input  logic        arstn_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        core_misalign_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);
    // state  | meaning
    // IDLE   | waiting for an aligned core request
    // BUSY   | request on the memory port, waiting for mem_ready_i
    // DONE   | one-cycle release of the stall after completion
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    logic [1:0]  state_q, state_d;
    logic [31:0] rd_q;
    logic        bad_access;
    logic        req_ok;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_data;

    always_comb begin
        bad_access = 1'b1;
        case (core_size_i)
            LDST_B:  bad_access = 1'b0;
            LDST_H:  bad_access = core_addr_i[0];
            LDST_W:  bad_access = |core_addr_i[1:0];
            LDST_BU: bad_access = core_we_i;
            LDST_HU: bad_access = core_we_i | core_addr_i[0];
            default: bad_access = 1'b1;
        endcase
    end

    assign core_misalign_o = core_req_i & bad_access;
    assign req_ok          = core_req_i & ~bad_access;
    assign mem_req_o       = ((state_q == S_IDLE) & req_ok) | (state_q == S_BUSY);
    assign core_stall_o    = mem_req_o;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req_ok)      state_d = S_BUSY;
            S_BUSY:  if (mem_ready_i) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign mem_we_o   = core_we_i;
    assign mem_addr_o = {core_addr_i[31:2], 2'b00};

    always_comb begin
        mem_be_o = 4'b0000;
        mem_wd_o = core_wd_i;
        case (core_size_i)
            LDST_B, LDST_BU: begin
                mem_be_o = 4'b0001 << core_addr_i[1:0];
                mem_wd_o = {4{core_wd_i[7:0]}};
            end
            LDST_H, LDST_HU: begin
                mem_be_o = 4'b0011 << {core_addr_i[1], 1'b0};
                mem_wd_o = {2{core_wd_i[15:0]}};
            end
            LDST_W:  mem_be_o = 4'b1111;
            default: mem_be_o = 4'b0000;
        endcase
    end

    always_comb begin
        case (core_addr_i[1:0])
            2'd0:    lane_byte = mem_rd_i[7:0];
            2'd1:    lane_byte = mem_rd_i[15:8];
            2'd2:    lane_byte = mem_rd_i[23:16];
            default: lane_byte = mem_rd_i[31:24];
        endcase
        lane_half = core_addr_i[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
        case (core_size_i)
            LDST_B:  load_data = {{24{lane_byte[7]}}, lane_byte};
            LDST_H:  load_data = {{16{lane_half[15]}}, lane_half};
            LDST_BU: load_data = {24'd0, lane_byte};
            LDST_HU: load_data = {16'd0, lane_half};
            default: load_data = mem_rd_i;
        endcase
    end

    // Load data is captured only on the completing edge; stores never touch it.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q <= S_IDLE;
            rd_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            if ((state_q == S_BUSY) && mem_ready_i && !core_we_i)
                rd_q <= load_data;
        end
    end

    assign core_rd_o = rd_q;

endmodule
